// File: rtl/req_gnt_arb_pkg.sv
// Shared types and constants for the round-robin req/gnt arbiter.
// Starvation watchdog is enabled by REQ_GNT_ARB_STARVE_CHECK_EN.
package req_gnt_arb_pkg;

    localparam int WAIT_W     = 8;
    localparam int PICK_IDX_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [PICK_IDX_W-1:0] idx;
    } pick_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/req_gnt_arbiter_rr_pick.sv
// Combinational wrapped-priority search starting at ptr.
// Wrap uses a compare against N-1 so N need not be a power of two.
module rr_pick
    import req_gnt_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output pick_t         pick
);

    logic [IW-1:0] cand;

    always_comb begin
        pick = '0;
        cand = ptr;
        for (int i = 0; i < N; i++) begin
            if (!pick.valid && req[cand]) begin
                pick.valid = 1'b1;
                pick.idx   = PICK_IDX_W'(cand);
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + IW'(1);
        end
    end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin arbiter with registered one-hot grant and bus lock.
// Define REQ_GNT_ARB_STARVE_CHECK_EN to build the starvation watchdog.
module req_gnt_arbiter
    import req_gnt_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_WAIT = 8,
    localparam int IW       = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          lock,
    output logic [N-1:0]  gnt,
    output logic          gnt_any,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  starve_err
);

    if (N < 2 || N > 16 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_cfg
        $error("req_gnt_arbiter: N or MAX_WAIT out of range");
    end

    logic [IW-1:0] ptr;
    pick_t         pick;
    logic          hold;
    logic [N-1:0]  nxt_gnt;
    logic [IW-1:0] nxt_idx;
    logic [IW-1:0] nxt_ptr;
    logic          nxt_any;

    rr_pick #(.N(N)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick)
    );

    // gnt is one-hot, so any overlap with req means the holder still asks
    assign hold = lock && (|(gnt & req));

    always_comb begin
        nxt_gnt = '0;
        nxt_idx = '0;
        nxt_ptr = ptr;
        nxt_any = 1'b0;
        if (hold) begin
            nxt_gnt = gnt;
            nxt_idx = gnt_idx;
            nxt_any = 1'b1;
        end else if (pick.valid) begin
            nxt_any = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (PICK_IDX_W'(k) == pick.idx) begin
                    nxt_gnt[k] = 1'b1;
                    nxt_idx    = IW'(k);
                    nxt_ptr    = (k == N - 1) ? '0 : IW'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt     <= '0;
            gnt_any <= 1'b0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            gnt     <= nxt_gnt;
            gnt_any <= nxt_any;
            gnt_idx <= nxt_idx;
            ptr     <= nxt_ptr;
        end
    end

`ifdef REQ_GNT_ARB_STARVE_CHECK_EN
    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt [N];

    // flag fires on the edge where the counter lands on MAX_W
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                wait_cnt[i] <= '0;
            end
            starve_err <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !gnt[i]) begin
                    if (wait_cnt[i] != MAX_W) begin
                        wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                    end
                    if (wait_cnt[i] >= MAX_W - WAIT_W'(1)) begin
                        starve_err[i] <= 1'b1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign starve_err = '0;
`endif

endmodule

// File: doc/req_gnt_arbiter.md
# req_gnt_arbiter

Round-robin request/grant arbiter that drives the `gnt` side of the req/gnt handshake consumed by the environment assumption block. It samples up to N request lines each cycle and returns a registered one-hot grant exactly one cycle later, so that `req |=> gnt` holds on the aggregate signals whenever reset is inactive. An optional bus-lock input and an optional starvation watchdog are provided.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAX_WAIT`, default 8: starvation threshold in cycles, 1..255. Used only when the watchdog is compiled in.
- `clk` input 1: single clock. All logic updates on posedge.
- `rst` input 1: synchronous, active-low reset, sampled on posedge `clk`.
- `req` input N: per-requester request, level-sensitive.
- `lock` input 1: holds the current grant holder while it keeps requesting.
- `gnt` output N: registered one-hot grant, or all zeros.
- `gnt_any` output 1: registered OR of `gnt`.
- `gnt_idx` output $clog2(N): index of the set bit of `gnt`. It is 0 when `gnt` is 0.
- `starve_err` output N: sticky per-requester starvation flags.

## Operation
- Reset: when `rst`=0 at a posedge, the block clears `gnt`, `gnt_any`, `gnt_idx`, `starve_err`, the pointer `ptr`, and all wait counters to 0.
- Pointer: `ptr` is $clog2(N) bits. It names the highest-priority requester for the next decision.
- Decision at posedge t, when `rst`=1, uses `req`, `lock` and the current `gnt`, all sampled at t:
  - Lock case: `lock`=1 and `gnt[k]`=1 and `req[k]`=1. Then `gnt` stays at bit k and `ptr` is unchanged.
  - No requests: `req`=0. Then `gnt` becomes 0 and `ptr` is unchanged.
  - Otherwise, search indices `ptr`, `ptr`+1, …, wrapping modulo N, and take the first k with `req[k]`=1. Then `gnt` becomes one-hot bit k and `ptr` becomes (k+1) mod N. Wrap-around uses an explicit compare against N-1, because N need not be a power of two.
- `gnt_any` and `gnt_idx` are registered in the same cycle as `gnt` and are always consistent with it.
- `lock` has no effect when `gnt` is 0 or when the holder has dropped its `req`. In that case normal round-robin applies.
- A requester may drop `req` while granted. Its grant is removed at the next edge and no error is raised.
- Invariant: `gnt` is never multi-hot. Every set `gnt[k]` at t+1 implies `req[k]` was 1 at t.

## Timing
- Latency: `req` at edge t gives `gnt` at edge t+1 (one cycle). There is no combinational path from `req` to `gnt`.
- Fairness: with `lock` held at 0, any continuously requesting line is granted within N cycles.
- Reset has priority over every other input in the same cycle, including in mid-grant.
- First decision after reset release starts with `ptr`=0.

## Configuration
- Macro `REQ_GNT_ARB_STARVE_CHECK_EN`.
- Defined: one wait counter per requester, 8 bits wide.
  - Increments, saturating at `MAX_WAIT`, on each edge where `req[i]`=1 and `gnt[i]`=0.
  - Clears when `req[i]`=0 or `gnt[i]`=1.
  - When the counter reaches `MAX_WAIT`, `starve_err[i]` is set on the same edge. It stays set until reset.
- Not defined: no counters exist, and `starve_err` is tied to 0.

## Structure
- Package `req_gnt_arb_pkg` holds:
  - the function computing the index width;
  - the wait-counter width constant (8);
  - the typedef for the decision record `{valid, idx}`.
- Sub-module `rr_pick`: purely combinational. Given `req` and `ptr`, it returns `{valid, idx}` using the wrapped priority search. The top level owns all registers, the lock logic and the watchdog.

## Test plan
All scenarios use N=4 and MAX_WAIT=4.
- Reset, then `req`=4'b0101 held → `gnt` = 0 for one cycle, then 0001, 0100, 0001, 0100 …; `gnt_idx` = 0, 2, 0, 2.
- `req`=4'b1111 held from `ptr`=0 → `gnt` = 0001, 0010, 0100, 1000, 0001; checks wrap from index 3 to 0.
- `req`=4'b0011 with `gnt`=0001, then `lock`=1 held → `gnt` stays 0001. With the macro defined, `starve_err` = 4'b0010 after 4 waiting cycles and stays set after `lock` drops.
- `req` 4'b0100 for one cycle, then 0 → `gnt`=0100 for exactly one cycle, then 0; `gnt_any` follows the same pattern.
- `rst`=0 for one edge while `gnt`=0100 and `req`=4'b0110 → next cycle `gnt`=0 and `ptr`=0; the following cycle `gnt`=0010.
- Random `req`/`lock` for 10k cycles → `gnt` is always one-hot or zero, `req |=> gnt_any` holds, and there is no grant without a prior request.
